// File: rtl/regfile_port_ctrl_if.sv
// Bus bundle for regfile_port_ctrl: operand-read request/response,
// writeback input, and the register-file read/write port.
interface regfile_port_ctrl_if;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [2:0]  rd_rs_addr;
    logic [2:0]  rd_rt_addr;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rs_data;
    logic [15:0] rsp_rt_data;

    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    logic        rf_write;
    logic [2:0]  rf_rd_addr;
    logic [15:0] rf_data;
    logic [2:0]  rf_rs_addr;
    logic [2:0]  rf_rt_addr;
    logic [15:0] rf_rs_data;
    logic [15:0] rf_rt_data;

    modport slave (
        input  rd_req_valid, rd_rs_addr, rd_rt_addr,
        output rd_req_ready,
        output rsp_valid, rsp_rs_data, rsp_rt_data,
        input  rsp_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output rf_write, rf_rd_addr, rf_data, rf_rs_addr, rf_rt_addr,
        input  rf_rs_data, rf_rt_data
    );

    modport master (
        output rd_req_valid, rd_rs_addr, rd_rt_addr,
        input  rd_req_ready,
        input  rsp_valid, rsp_rs_data, rsp_rt_data,
        output rsp_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  rf_write, rf_rd_addr, rf_data, rf_rs_addr, rf_rt_addr,
        output rf_rs_data, rf_rt_data
    );
endinterface

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: buffers writebacks in a small FIFO that
// drains through the single write port whenever the read pipeline is not
// using the array, and serves operand reads with a RAW hazard block.
//
// state   | meaning
// IDLE    | waiting for a read request; FIFO may drain
// ISSUE   | read addresses applied, write port held off so the array reads
// CAPTURE | array read data captured into the response registers
// RESP    | response presented until accepted
module regfile_port_ctrl #(
    parameter int WB_DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    regfile_port_ctrl_if.slave  bus
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic [2:0]    r_wb_addr [WB_DEPTH];
    logic [15:0]   r_wb_data [WB_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [2:0]    r_rs_addr;
    logic [2:0]    r_rt_addr;
    logic [15:0]   r_rs_data;
    logic [15:0]   r_rt_data;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_hazard;
    logic          w_rd_accept;
    logic          w_rsp_accept;

    assign w_full       = (r_count == CW'(WB_DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = bus.wb_valid && !w_full;
    // The array is only free for writes outside ISSUE.
    assign w_pop        = !w_empty && (r_state != ISSUE);
    assign w_rd_accept  = bus.rd_req_valid && bus.rd_req_ready;
    assign w_rsp_accept = (r_state == RESP) && bus.rsp_ready;

    assign bus.wb_ready     = !w_full;
    assign bus.rd_req_ready = (r_state == IDLE) && !w_hazard;
    assign bus.rsp_valid    = (r_state == RESP);
    assign bus.rsp_rs_data  = r_rs_data;
    assign bus.rsp_rt_data  = r_rt_data;
    assign bus.rf_rs_addr   = r_rs_addr;
    assign bus.rf_rt_addr   = r_rt_addr;
    assign bus.rf_write     = w_pop;
    assign bus.rf_rd_addr   = w_pop ? r_wb_addr[r_rd_ptr] : 3'd0;
    assign bus.rf_data      = w_pop ? r_wb_data[r_rd_ptr] : 16'd0;

    // RAW check against every buffered entry, the head included even while it pops.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CW'(i) < r_count) begin
                if ((r_wb_addr[r_rd_ptr + PW'(i)] == bus.rd_rs_addr) ||
                    (r_wb_addr[r_rd_ptr + PW'(i)] == bus.rd_rt_addr)) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents are don't-care while outside the occupancy window.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= bus.wb_addr;
            r_wb_data[r_wr_ptr] <= bus.wb_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_rd_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = CAPTURE;
            CAPTURE: w_next_state = RESP;
            RESP:    if (w_rsp_accept) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Latch read addresses on accept and capture array data on leaving CAPTURE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rs_addr <= '0;
            r_rt_addr <= '0;
            r_rs_data <= '0;
            r_rt_data <= '0;
        end else begin
            if (w_rd_accept) begin
                r_rs_addr <= bus.rd_rs_addr;
                r_rt_addr <= bus.rd_rt_addr;
            end
            if (r_state == CAPTURE) begin
                r_rs_data <= bus.rf_rs_data;
                r_rt_data <= bus.rf_rt_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: behavioural register file, directed vectors,
// expected responses and writes queued at accept and checked by a monitor.
`timescale 1ns/1ps
module tb_regfile_port_ctrl;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    regfile_port_ctrl_if bus();

    regfile_port_ctrl #(.WB_DEPTH(2)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int          n_cmp   = 0;
    int          n_err   = 0;
    int          cyc     = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_q [$];
    logic [18:0] wbq   [$];
    logic        prev_rsp_valid = 1'b0;
    logic [15:0] rf_mem [8] = '{16'h1000, 16'h1001, 16'h1002, 16'h1003,
                                16'h1004, 16'h1005, 16'h1006, 16'h1007};

    always @(posedge clock) cyc <= cyc + 1;

    // Register file: write port wins; read data registered on non-write edges.
    always @(posedge clock) begin
        if (bus.rf_write) begin
            rf_mem[bus.rf_rd_addr] <= bus.rf_data;
        end else begin
            bus.rf_rs_data <= rf_mem[bus.rf_rs_addr];
            bus.rf_rt_data <= rf_mem[bus.rf_rt_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Monitor: values seen at negedge are what the next rising edge transfers.
    always @(negedge clock) begin
        logic [31:0] e;
        logic [18:0] w;
        if (!reset_n) begin
            prev_rsp_valid = 1'b0;
        end else begin
            if (bus.rf_write) begin
                if (wbq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rf_write_unexpected: got write addr %0d data %h, required no write",
                             bus.rf_rd_addr, bus.rf_data);
                end else begin
                    w = wbq.pop_front();
                    check("rf_wr_addr", 32'(bus.rf_rd_addr), 32'(w[18:16]));
                    check("rf_wr_data", 32'(bus.rf_data), 32'(w[15:0]));
                end
            end
            if (bus.rsp_valid) begin
                if (!prev_rsp_valid) check("rsp_latency", cyc - acc_cyc, 32'd3);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got rsp_valid with %h/%h, required no response",
                             bus.rsp_rs_data, bus.rsp_rt_data);
                end else begin
                    e = exp_q[0];
                    check("rsp_rs_data", 32'(bus.rsp_rs_data), 32'(e[31:16]));
                    check("rsp_rt_data", 32'(bus.rsp_rt_data), 32'(e[15:0]));
                    if (bus.rsp_ready) void'(exp_q.pop_front());
                end
            end
            prev_rsp_valid = bus.rsp_valid;
        end
    end

    task automatic wb_push(input logic [2:0] a, input logic [15:0] d);
        int n = 0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        @(negedge clock);
        while (!bus.wb_ready && n < 50) begin
            n++;
            @(negedge clock);
        end
        if (!bus.wb_ready) timeout_fail("wb_push");
        else wbq.push_back({a, d});
        @(posedge clock);
        #1 bus.wb_valid = 1'b0;
    endtask

    task automatic rd_req(input logic [2:0] rs, input logic [2:0] rt,
                          input logic [15:0] ers, input logic [15:0] ert, output int blocked);
        blocked = 0;
        bus.rd_req_valid = 1'b1;
        bus.rd_rs_addr   = rs;
        bus.rd_rt_addr   = rt;
        @(negedge clock);
        while (!bus.rd_req_ready && blocked < 50) begin
            blocked++;
            @(negedge clock);
        end
        if (!bus.rd_req_ready) begin
            timeout_fail("rd_req");
        end else begin
            exp_q.push_back({ers, ert});
            acc_cyc = cyc;
        end
        @(posedge clock);
        #1 bus.rd_req_valid = 1'b0;
    endtask

    // Read request and writeback presented together from an idle, empty state.
    task automatic rd_and_wb(input string tag, input logic [2:0] rs, input logic [2:0] rt,
                             input logic [15:0] ers, input logic [15:0] ert,
                             input logic [2:0] wa, input logic [15:0] wd);
        bus.rd_req_valid = 1'b1;
        bus.rd_rs_addr   = rs;
        bus.rd_rt_addr   = rt;
        bus.wb_valid     = 1'b1;
        bus.wb_addr      = wa;
        bus.wb_data      = wd;
        @(negedge clock);
        check({tag, "_rd_ready"}, 32'(bus.rd_req_ready), 32'd1);
        check({tag, "_wb_ready"}, 32'(bus.wb_ready), 32'd1);
        if (bus.rd_req_ready) begin
            exp_q.push_back({ers, ert});
            acc_cyc = cyc;
        end
        if (bus.wb_ready) wbq.push_back({wa, wd});
        @(posedge clock);
        #1;
        bus.rd_req_valid = 1'b0;
        bus.wb_valid     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        @(negedge clock);
        while ((exp_q.size() != 0 || wbq.size() != 0 || bus.rsp_valid) && n < 40) begin
            n++;
            @(negedge clock);
        end
        if (exp_q.size() != 0 || wbq.size() != 0 || bus.rsp_valid) timeout_fail(tag);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int blk;
        int n;
        bus.rd_req_valid = 1'b0;
        bus.rd_rs_addr   = 3'd0;
        bus.rd_rt_addr   = 3'd0;
        bus.rsp_ready    = 1'b1;
        bus.wb_valid     = 1'b0;
        bus.wb_addr      = 3'd0;
        bus.wb_data      = 16'd0;

        // Reset values.
        #1;
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rf_write", 32'(bus.rf_write), 32'd0);
        check("rst_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("rst_rsp_rs", 32'(bus.rsp_rs_data), 32'd0);
        check("rst_rf_rs_addr", 32'(bus.rf_rs_addr), 32'd0);
        #22 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Writeback r3 then read it back with r0.
        wb_push(3'd3, 16'h1234);
        rd_req(3'd3, 3'd0, 16'h1234, 16'h1000, blk);
        wait_idle("t1_idle");

        // Read of r5 blocked while r5 is buffered.
        wb_push(3'd5, 16'hAAAA);
        rd_req(3'd5, 3'd3, 16'hAAAA, 16'h1234, blk);
        check("t2_blocked_cycles", blk, 32'd1);
        wait_idle("t2_idle");

        // Three back-to-back writebacks around a read: FIFO fills at two.
        rd_and_wb("t3", 3'd6, 3'd7, 16'h1006, 16'h1007, 3'd1, 16'h1111);
        wb_push(3'd2, 16'h2222);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 3'd4;
        bus.wb_data  = 16'h4444;
        @(negedge clock);
        check("t3_wb_ready_full", 32'(bus.wb_ready), 32'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("t3_wb_ready_after_pop", 32'(bus.wb_ready), 32'd1);
        if (bus.wb_ready) wbq.push_back({3'd4, 16'h4444});
        @(posedge clock);
        #1 bus.wb_valid = 1'b0;
        wait_idle("t3_idle");

        // Response back-pressure: held stable, FIFO drains, reads refused.
        bus.rsp_ready = 1'b0;
        rd_and_wb("t4", 3'd1, 3'd2, 16'h1111, 16'h2222, 3'd1, 16'hBEEF);
        wb_push(3'd2, 16'h5555);
        n = 0;
        @(negedge clock);
        while (!bus.rsp_valid && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!bus.rsp_valid) timeout_fail("t4_rsp_valid");
        bus.rd_req_valid = 1'b1;
        bus.rd_rs_addr   = 3'd4;
        bus.rd_rt_addr   = 3'd5;
        for (int i = 0; i < 5; i++) begin
            check("t4_rsp_held", 32'(bus.rsp_valid), 32'd1);
            check("t4_rd_refused", 32'(bus.rd_req_ready), 32'd0);
            @(negedge clock);
        end
        check("t4_fifo_drained", wbq.size(), 32'd0);
        @(posedge clock);
        #1 bus.rsp_ready = 1'b1;
        rd_req(3'd4, 3'd5, 16'h4444, 16'hAAAA, blk);
        wait_idle("t4_idle_a");
        rd_req(3'd1, 3'd2, 16'hBEEF, 16'h5555, blk);
        wait_idle("t4_idle_b");

        // Reset in CAPTURE with two writebacks buffered.
        rd_and_wb("t5", 3'd3, 3'd1, 16'h1234, 16'hBEEF, 3'd6, 16'h6666);
        wb_push(3'd7, 16'h7777);
        #2 reset_n = 1'b0;
        #1;
        check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("t5_rst_rsp_rs", 32'(bus.rsp_rs_data), 32'd0);
        check("t5_rst_rsp_rt", 32'(bus.rsp_rt_data), 32'd0);
        check("t5_rst_rf_write", 32'(bus.rf_write), 32'd0);
        check("t5_rst_rf_rd_addr", 32'(bus.rf_rd_addr), 32'd0);
        check("t5_rst_rf_data", 32'(bus.rf_data), 32'd0);
        check("t5_rst_rf_rs_addr", 32'(bus.rf_rs_addr), 32'd0);
        check("t5_rst_rf_rt_addr", 32'(bus.rf_rt_addr), 32'd0);
        exp_q.delete();
        wbq.delete();
        @(posedge clock);
        @(posedge clock);
        #3 reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("t5_wb_ready", 32'(bus.wb_ready), 32'd1);
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clock);
        #1;
        rd_req(3'd6, 3'd7, 16'h1006, 16'h1007, blk);
        wait_idle("t5_idle");

        // Same-cycle writeback and read of r7: old value first, new value after.
        rd_and_wb("t6", 3'd7, 3'd0, 16'h1007, 16'h1000, 3'd7, 16'h00FF);
        wait_idle("t6_idle_a");
        rd_req(3'd7, 3'd7, 16'h00FF, 16'h00FF, blk);
        wait_idle("t6_idle_b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
